// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet TX framer: state encoding,
// frame-size limits and the header word selector.
package eth_tx_pkg;

  localparam int DATA_W = 32;
  localparam int HDR_WORDS = 4;
  localparam int DEF_MIN_WORDS = 11;
  localparam int DEF_MAX_WORDS = 368;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD
  } state_t;

  // Big-endian header: dst MAC, src MAC, ethertype, then the 16-bit sequence.
  function automatic logic [DATA_W-1:0] hdr_word(input logic [47:0] dst,
                                                 input logic [47:0] src,
                                                 input logic [15:0] etype,
                                                 input logic [15:0] seq,
                                                 input logic [1:0]  idx);
    case (idx)
      2'd0:    return dst[47:16];
      2'd1:    return {dst[15:0], src[47:32]};
      2'd2:    return src[31:0];
      default: return {etype, seq};
    endcase
  endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// Frames upstream payload words into Ethernet frames for the MAC ff_tx stream:
// 4 header words, N payload words (zero-latency pass-through), zero pad to minimum.
module eth_tx_framer
  import eth_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0201_0203_0405,
  parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
  parameter int          MAX_WORDS = DEF_MAX_WORDS,
  parameter int          MIN_WORDS = DEF_MIN_WORDS
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [8:0]        i_len_words,
  output logic              o_busy,
  output logic              o_len_err,
  input  logic [DATA_W-1:0] i_pl_data,
  input  logic              i_pl_vld,
  output logic              o_pl_rdy,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_vld,
  output logic              o_tx_sop,
  output logic              o_tx_eop,
  input  logic              i_tx_rdy,
  output logic [15:0]       o_seq,
  output logic [15:0]       o_frame_cnt
);

  localparam logic [8:0] MAX_L    = 9'(MAX_WORDS);
  localparam logic [8:0] MIN_L    = 9'(MIN_WORDS);
  localparam logic [1:0] HDR_LAST = 2'(HDR_WORDS - 1);

  state_t      state, state_nxt;
  logic [1:0]  hdr_idx;
  logic [8:0]  word_cnt;
  logic [8:0]  len_q;
  logic [15:0] seq;
  logic [15:0] frame_cnt;
  logic        len_err;

  logic req_zero, req_clamp, req_take;
  logic last_pl, last_pad, xfer, eop_xfer;

  assign req_zero  = (i_len_words == 9'd0);
  assign req_clamp = (i_len_words > MAX_L);
  assign req_take  = (state == ST_IDLE) && i_start && !req_zero;

  // word_cnt keeps counting through PAD, so the pad ends when it reaches MIN-1.
  assign last_pl  = (word_cnt == len_q - 9'd1);
  assign last_pad = (word_cnt == MIN_L - 9'd1);

  assign xfer     = o_tx_vld && i_tx_rdy;
  assign eop_xfer = xfer && o_tx_eop;

  assign o_busy      = (state != ST_IDLE);
  assign o_len_err   = len_err;
  assign o_seq       = seq;
  assign o_frame_cnt = frame_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_tx_data = '0;
    o_tx_vld  = 1'b0;
    o_tx_sop  = 1'b0;
    o_tx_eop  = 1'b0;
    o_pl_rdy  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_take) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        o_tx_vld  = 1'b1;
        o_tx_data = hdr_word(DST_MAC, SRC_MAC, ETHERTYPE, seq, hdr_idx);
        o_tx_sop  = (hdr_idx == 2'd0);
        if (i_tx_rdy && hdr_idx == HDR_LAST) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        o_tx_data = i_pl_data;
        o_tx_vld  = i_pl_vld;
        o_pl_rdy  = i_tx_rdy;
        o_tx_eop  = last_pl && (len_q >= MIN_L);
        if (i_pl_vld && i_tx_rdy && last_pl)
          state_nxt = (len_q < MIN_L) ? ST_PAD : ST_IDLE;
      end
      ST_PAD: begin
        o_tx_vld = 1'b1;
        o_tx_eop = last_pad;
        if (i_tx_rdy && last_pad) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_idx   <= 2'd0;
      word_cnt  <= 9'd0;
      len_q     <= 9'd0;
      seq       <= 16'd0;
      frame_cnt <= 16'd0;
      len_err   <= 1'b0;
    end else begin
      len_err <= (state == ST_IDLE) && i_start && (req_zero || req_clamp);
      if (req_take) begin
        len_q    <= req_clamp ? MAX_L : i_len_words;
        hdr_idx  <= 2'd0;
        word_cnt <= 9'd0;
      end
      if (state == ST_HDR && xfer) hdr_idx <= hdr_idx + 2'd1;
      if ((state == ST_PAYLOAD || state == ST_PAD) && xfer) word_cnt <= word_cnt + 9'd1;
      if (eop_xfer) begin
        seq       <= seq + 16'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: frame contents, padding, clamping,
// stalls/bubbles, sequence wrap and asynchronous reset.
module tb_eth_tx_framer;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_len_words = '0;
  logic        o_busy, o_len_err, o_pl_rdy;
  logic [31:0] i_pl_data = '0;
  logic        i_pl_vld = 1'b0;
  logic [31:0] o_tx_data;
  logic        o_tx_vld, o_tx_sop, o_tx_eop;
  logic        i_tx_rdy = 1'b0;
  logic [15:0] o_seq, o_frame_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  eth_tx_framer dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .i_start(i_start), .i_len_words(i_len_words),
    .o_busy(o_busy), .o_len_err(o_len_err), .i_pl_data(i_pl_data), .i_pl_vld(i_pl_vld),
    .o_pl_rdy(o_pl_rdy), .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .o_tx_sop(o_tx_sop),
    .o_tx_eop(o_tx_eop), .i_tx_rdy(i_tx_rdy), .o_seq(o_seq), .o_frame_cnt(o_frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic run_frame(input string tag, input int len_req, input int pct_rdy,
                           input int pct_vld, input logic [31:0] base, input bit poke_start);
    int L, exp_words, widx, pl_idx, cyc;
    int len_err_cnt, rdy_bad, stall_bad, bad_words, sop_bad, eop_bad;
    logic [15:0] seq0, cnt0;
    logic [31:0] exp_w, w0, w3, last_w, hold_d;
    logic hold_sop, hold_eop, stalled, done, accept;
    L = (len_req > 368) ? 368 : len_req;
    exp_words = 4 + ((L < 11) ? 11 : L);
    seq0 = o_seq;
    cnt0 = o_frame_cnt;
    {len_err_cnt, rdy_bad, stall_bad, bad_words, sop_bad, eop_bad} = '0;
    {widx, pl_idx, cyc} = '0;
    {stalled, done} = '0;
    {w0, w3, last_w, hold_d, hold_sop, hold_eop} = '0;
    @(posedge sys_clk); #1;
    i_start = 1'b1;
    i_len_words = 9'(len_req);
    i_tx_rdy = roll(pct_rdy);
    i_pl_vld = roll(pct_vld);
    i_pl_data = base;
    @(posedge sys_clk); #1;
    i_start = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
      if (o_len_err) len_err_cnt++;
      if (o_pl_rdy && (widx < 4 || widx >= 4 + L)) rdy_bad++;
      if (stalled && (!o_tx_vld || o_tx_data !== hold_d || o_tx_sop !== hold_sop ||
                      o_tx_eop !== hold_eop)) stall_bad++;
      accept = i_pl_vld && o_pl_rdy;
      if (o_tx_vld && i_tx_rdy) begin
        case (widx)
          0: exp_w = 32'hFFFF_FFFF;
          1: exp_w = 32'hFFFF_0201;
          2: exp_w = 32'h0203_0405;
          3: exp_w = {16'h88B5, seq0};
          default: exp_w = (widx < 4 + L) ? base + 32'(widx - 4) : 32'h0;
        endcase
        if (o_tx_data !== exp_w) bad_words++;
        if (o_tx_sop !== (widx == 0)) sop_bad++;
        if (o_tx_eop !== (widx == exp_words - 1)) eop_bad++;
        if (widx == 0) w0 = o_tx_data;
        if (widx == 3) w3 = o_tx_data;
        last_w = o_tx_data;
        widx++;
        if (o_tx_eop) done = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = o_tx_vld;
      end
      hold_d = o_tx_data;
      hold_sop = o_tx_sop;
      hold_eop = o_tx_eop;
      @(posedge sys_clk); #1;
      if (accept) pl_idx++;
      if (poke_start && cyc == 10) begin
        i_start = 1'b1;
        i_len_words = 9'd5;
      end else begin
        i_start = 1'b0;
      end
      i_tx_rdy = roll(pct_rdy);
      if (!(i_pl_vld && !accept)) i_pl_vld = (pl_idx < L) && roll(pct_vld);
      i_pl_data = base + 32'(pl_idx);
    end
    i_pl_vld = 1'b0;
    i_start = 1'b0;
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_nwords"}, 64'(widx), 64'(exp_words));
    check_eq({tag, "_badwords"}, 64'(bad_words), 64'd0);
    check_eq({tag, "_w0"}, 64'(w0), 64'hFFFF_FFFF);
    check_eq({tag, "_w3"}, 64'(w3), {32'h0, 16'h88B5, seq0});
    check_eq({tag, "_last"}, 64'(last_w), (L >= 11) ? 64'(base + 32'(L - 1)) : 64'h0);
    check_eq({tag, "_sop"}, 64'(sop_bad), 64'd0);
    check_eq({tag, "_eop"}, 64'(eop_bad), 64'd0);
    check_eq({tag, "_plrdy"}, 64'(rdy_bad), 64'd0);
    check_eq({tag, "_stall"}, 64'(stall_bad), 64'd0);
    check_eq({tag, "_lenerr"}, 64'(len_err_cnt), (len_req > 368) ? 64'd1 : 64'd0);
    @(negedge sys_clk);
    check_eq({tag, "_idle"}, 64'(o_busy), 64'd0);
    check_eq({tag, "_seq"}, 64'(o_seq), 64'(16'(seq0 + 16'd1)));
    check_eq({tag, "_fcnt"}, 64'(o_frame_cnt), 64'(16'(cnt0 + 16'd1)));
  endtask

  initial begin
    #23;
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_vld", 64'(o_tx_vld), 64'd0);
    check_eq("rst_data", 64'(o_tx_data), 64'd0);
    check_eq("rst_seq", 64'(o_seq), 64'd0);
    check_eq("rst_fcnt", 64'(o_frame_cnt), 64'd0);
    check_eq("rst_plrdy", 64'(o_pl_rdy), 64'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    run_frame("l20", 20, 100, 100, 32'h1000, 1'b0);
    check_eq("l20_seq1", 64'(o_seq), 64'd1);
    run_frame("l3", 3, 100, 100, 32'h2000, 1'b0);
    run_frame("l400", 400, 100, 100, 32'h3000, 1'b0);

    @(posedge sys_clk); #1;
    i_start = 1'b1;
    i_len_words = 9'd0;
    @(posedge sys_clk); #1;
    i_start = 1'b0;
    @(negedge sys_clk);
    check_eq("l0_err", 64'(o_len_err), 64'd1);
    check_eq("l0_busy", 64'(o_busy), 64'd0);
    check_eq("l0_vld", 64'(o_tx_vld), 64'd0);
    @(negedge sys_clk);
    check_eq("l0_err_pulse", 64'(o_len_err), 64'd0);
    check_eq("l0_vld2", 64'(o_tx_vld), 64'd0);

    run_frame("l50r", 50, 60, 70, 32'h5000, 1'b1);

    @(negedge sys_clk);
    force dut.seq = 16'hFFFF;
    @(posedge sys_clk);
    @(negedge sys_clk);
    release dut.seq;
    check_eq("wrap_pre", 64'(o_seq), 64'hFFFF);
    run_frame("wrap", 11, 100, 100, 32'h6000, 1'b0);
    check_eq("wrap_zero", 64'(o_seq), 64'd0);

    @(posedge sys_clk); #1;
    i_start = 1'b1;
    i_len_words = 9'd20;
    i_tx_rdy = 1'b1;
    i_pl_vld = 1'b1;
    i_pl_data = 32'hABCD_0001;
    @(posedge sys_clk); #1;
    i_start = 1'b0;
    repeat (6) @(posedge sys_clk);
    #2;
    check_eq("mid_vld", 64'(o_tx_vld), 64'd1);
    check_eq("mid_data", 64'(o_tx_data), 64'hABCD_0001);
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 64'(o_tx_vld), 64'd0);
    check_eq("arst_data", 64'(o_tx_data), 64'd0);
    check_eq("arst_busy", 64'(o_busy), 64'd0);
    check_eq("arst_plrdy", 64'(o_pl_rdy), 64'd0);
    check_eq("arst_seq", 64'(o_seq), 64'd0);
    check_eq("arst_fcnt", 64'(o_frame_cnt), 64'd0);
    i_pl_vld = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
